// File: rtl/ctu_cluster_rst_seq.sv
// Cluster reset sequencer: staggers per-cluster clock enables, then releases the
// global reset and debug-init, and services debug-init and warm-reset requests.
module ctu_cluster_rst_seq #(
    parameter int NCLK     = 4,
    parameter int CKEN_GAP = 2,
    parameter int RST_HOLD = 16,
    parameter int DBG_LEN  = 8
) (
    input  logic            gclk,
    input  logic            arst,
    input  logic            wrst_req,
    input  logic            dbg_req,
    input  logic [NCLK-1:0] cluster_en,
    output logic [NCLK-1:0] cluster_cken,
    output logic            grst_l,
    output logic            gdbginit_l,
    output logic            rst_busy,
    output logic            dbg_ack
);

    localparam int SLOT_W = $clog2(NCLK + 1);
    localparam int GAP_W  = $clog2(CKEN_GAP + 1);
    localparam int HOLD_W = $clog2(RST_HOLD + 1);
    localparam int DBG_W  = $clog2(DBG_LEN + 1);

    typedef enum logic [2:0] {
        ST_RST  = 3'd0,
        ST_CKEN = 3'd1,
        ST_HOLD = 3'd2,
        ST_RUN  = 3'd3,
        ST_DBG  = 3'd4,
        ST_WRST = 3'd5
    } state_t;

    state_t            state_r, state_s;
    logic [SLOT_W-1:0] slot_r, slot_s;
    logic [GAP_W-1:0]  gap_r, gap_s;
    logic [HOLD_W-1:0] hold_r, hold_s;
    logic [DBG_W-1:0]  dbg_cnt_r, dbg_cnt_s;
    logic [NCLK-1:0]   cken_r, cken_s;
    logic              grst_l_r, grst_l_s;
    logic              gdbg_l_r, gdbg_l_s;
    logic              busy_r, busy_s;
    logic              ack_r, ack_s;

    // State, counter and output registers; arst forces the cold-reset image.
    always_ff @(posedge gclk or posedge arst) begin
        if (arst) begin
            state_r   <= ST_RST;
            slot_r    <= {SLOT_W{1'b0}};
            gap_r     <= {GAP_W{1'b0}};
            hold_r    <= {HOLD_W{1'b0}};
            dbg_cnt_r <= {DBG_W{1'b0}};
            cken_r    <= {NCLK{1'b0}};
            grst_l_r  <= 1'b0;
            gdbg_l_r  <= 1'b0;
            busy_r    <= 1'b1;
            ack_r     <= 1'b0;
        end else begin
            state_r   <= state_s;
            slot_r    <= slot_s;
            gap_r     <= gap_s;
            hold_r    <= hold_s;
            dbg_cnt_r <= dbg_cnt_s;
            cken_r    <= cken_s;
            grst_l_r  <= grst_l_s;
            gdbg_l_r  <= gdbg_l_s;
            busy_r    <= busy_s;
            ack_r     <= ack_s;
        end
    end

    // Next-state, counter and next-output logic.
    always_comb begin
        state_s   = state_r;
        slot_s    = slot_r;
        gap_s     = gap_r;
        hold_s    = hold_r;
        dbg_cnt_s = dbg_cnt_r;
        cken_s    = cken_r;
        grst_l_s  = grst_l_r;
        gdbg_l_s  = gdbg_l_r;
        busy_s    = busy_r;
        ack_s     = 1'b0;

        case (state_r)
            ST_RST: begin
                state_s   = ST_CKEN;
                slot_s    = {SLOT_W{1'b0}};
                gap_s     = {GAP_W{1'b0}};
                hold_s    = {HOLD_W{1'b0}};
                dbg_cnt_s = {DBG_W{1'b0}};
                cken_s    = {NCLK{1'b0}};
                grst_l_s  = 1'b0;
                gdbg_l_s  = 1'b0;
                busy_s    = 1'b1;
            end

            ST_CKEN: begin
                // A disabled cluster still spends its slot so timing never depends on the mask.
                if (gap_r == GAP_W'(CKEN_GAP - 1)) begin
                    for (int i = 0; i < NCLK; i++) begin
                        if (slot_r == SLOT_W'(i)) begin
                            cken_s[i] = cluster_en[i];
                        end else begin
                            cken_s[i] = cken_r[i];
                        end
                    end
                    gap_s = {GAP_W{1'b0}};
                    if (slot_r == SLOT_W'(NCLK - 1)) begin
                        state_s = ST_HOLD;
                        slot_s  = {SLOT_W{1'b0}};
                        hold_s  = {HOLD_W{1'b0}};
                    end else begin
                        slot_s = slot_r + SLOT_W'(1);
                    end
                end else begin
                    gap_s = gap_r + GAP_W'(1);
                end
            end

            ST_HOLD: begin
                if (hold_r == HOLD_W'(RST_HOLD - 1)) begin
                    state_s  = ST_RUN;
                    hold_s   = {HOLD_W{1'b0}};
                    grst_l_s = 1'b1;
                    gdbg_l_s = 1'b1;
                    busy_s   = 1'b0;
                end else begin
                    hold_s = hold_r + HOLD_W'(1);
                end
            end

            ST_RUN: begin
                // Warm reset outranks a simultaneous debug-init request.
                if (wrst_req) begin
                    state_s  = ST_WRST;
                    cken_s   = {NCLK{1'b0}};
                    grst_l_s = 1'b0;
                    gdbg_l_s = 1'b0;
                    busy_s   = 1'b1;
                end else if (dbg_req) begin
                    state_s   = ST_DBG;
                    dbg_cnt_s = {DBG_W{1'b0}};
                    gdbg_l_s  = 1'b0;
                end else begin
                    state_s = ST_RUN;
                end
            end

            ST_DBG: begin
                if (wrst_req) begin
                    state_s   = ST_WRST;
                    dbg_cnt_s = {DBG_W{1'b0}};
                    cken_s    = {NCLK{1'b0}};
                    grst_l_s  = 1'b0;
                    gdbg_l_s  = 1'b0;
                    busy_s    = 1'b1;
                end else if (dbg_cnt_r == DBG_W'(DBG_LEN - 1)) begin
                    state_s   = ST_RUN;
                    dbg_cnt_s = {DBG_W{1'b0}};
                    gdbg_l_s  = 1'b1;
                    ack_s     = 1'b1;
                end else begin
                    dbg_cnt_s = dbg_cnt_r + DBG_W'(1);
                end
            end

            ST_WRST: begin
                if (!wrst_req) begin
                    state_s   = ST_CKEN;
                    slot_s    = {SLOT_W{1'b0}};
                    gap_s     = {GAP_W{1'b0}};
                    hold_s    = {HOLD_W{1'b0}};
                    dbg_cnt_s = {DBG_W{1'b0}};
                end else begin
                    state_s = ST_WRST;
                end
            end

            default: begin
                state_s   = ST_RST;
                slot_s    = {SLOT_W{1'b0}};
                gap_s     = {GAP_W{1'b0}};
                hold_s    = {HOLD_W{1'b0}};
                dbg_cnt_s = {DBG_W{1'b0}};
                cken_s    = {NCLK{1'b0}};
                grst_l_s  = 1'b0;
                gdbg_l_s  = 1'b0;
                busy_s    = 1'b1;
            end
        endcase
    end

    assign cluster_cken = cken_r;
    assign grst_l       = grst_l_r;
    assign gdbginit_l   = gdbg_l_r;
    assign rst_busy     = busy_r;
    assign dbg_ack      = ack_r;

endmodule

// File: doc/ctu_cluster_rst_seq.md
CTU_CLUSTER_RST_SEQ -- requirements
Module: ctu_cluster_rst_seq

Interface
REQ-001 SHALL have parameter NCLK, default 4, number of cluster headers driven (range 1..16).
REQ-002 SHALL have parameter CKEN_GAP, default 2, cycles between successive cluster clock-enable slots (range 1 or more).
REQ-003 SHALL have parameter RST_HOLD, default 16, cycles from the last cken slot to the grst_l release (range 1 or more).
REQ-004 SHALL have parameter DBG_LEN, default 8, gdbginit_l low-pulse length in cycles (range 1 or more).
REQ-005 SHALL have port gclk, input, 1 bit: the one clock of the block, rising-edge.
REQ-006 SHALL have port arst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have port wrst_req, input, 1 bit: warm-reset request, level, synchronous to gclk.
REQ-008 SHALL have port dbg_req, input, 1 bit: debug-init request, sampled each cycle.
REQ-009 SHALL have port cluster_en, input, NCLK bits: per-cluster enable mask, sampled at that cluster's slot.
REQ-010 SHALL have port cluster_cken, output, NCLK bits: registered per-cluster clock enables, one bit per cluster header.
REQ-011 SHALL have port grst_l, output, 1 bit: registered global reset to the cluster headers, active-low.
REQ-012 SHALL have port gdbginit_l, output, 1 bit: registered global debug-init, active-low.
REQ-013 SHALL have port rst_busy, output, 1 bit: high while a reset sequence is in progress.
REQ-014 SHALL have port dbg_ack, output, 1 bit: one-cycle pulse when a debug-init completes.

Function
REQ-015 SHALL implement the states RST, CKEN, HOLD, RUN, DBG and WRST.
REQ-016 SHALL count edges as follows: edge 1 is the first gclk rising edge after arst falls; on edge 1 the state goes RST to CKEN, with slot index 0 and the gap counter cleared.
REQ-017 In CKEN, cluster_cken[i] SHALL take the value of cluster_en[i], as sampled at that edge, at edge 1+(i+1)*CKEN_GAP.
REQ-018 A disabled cluster SHALL still consume its slot, so sequence timing is independent of cluster_en.
REQ-019 After slot NCLK-1 the state SHALL go to HOLD, with a counter counting RST_HOLD cycles.
REQ-020 At edge 1+NCLK*CKEN_GAP+RST_HOLD, grst_l SHALL go to 1, gdbginit_l SHALL go to 1, rst_busy SHALL go to 0, and the state SHALL go to RUN.
REQ-021 In RUN, cluster_cken SHALL hold its latched value; cluster_en changes SHALL take effect only in the next CKEN sequence.
REQ-022 When dbg_req=1 in RUN, the next edge SHALL drive gdbginit_l to 0 and enter DBG; grst_l and cluster_cken SHALL be unchanged.
REQ-023 gdbginit_l SHALL stay low for exactly DBG_LEN cycles; on the edge it returns to 1, dbg_ack SHALL be 1 for one cycle and the state SHALL return to RUN.
REQ-024 dbg_req asserted in DBG, RST, CKEN, HOLD or WRST SHALL be ignored and not queued.
REQ-025 When wrst_req=1 in RUN or DBG, the next edge SHALL enter WRST and drive grst_l=0, gdbginit_l=0, cluster_cken=all 0 and rst_busy=1.
REQ-026 A DBG sequence aborted by wrst_req SHALL produce no dbg_ack.
REQ-027 When wrst_req and dbg_req are both 1 in the same RUN cycle, wrst_req SHALL win and dbg_req SHALL be dropped.
REQ-028 WRST SHALL hold while wrst_req=1; on the first edge at which wrst_req=0, it SHALL enter CKEN with counters cleared, with timing identical to REQ-017..020 relative to that edge.
REQ-029 wrst_req in CKEN or HOLD SHALL be ignored, so the sequence always completes.
REQ-030 All counters SHALL be sized for their parameter maximum plus 1 and SHALL never wrap within a sequence.
REQ-031 State and counter updates SHALL be synchronous to gclk; only arst is asynchronous.

Reset
REQ-032 While arst=1, the block SHALL drive cluster_cken=0, grst_l=0, gdbginit_l=0, rst_busy=1, dbg_ack=0, state=RST, and all counters=0, with no gclk edge required.
REQ-033 arst asserted mid-sequence in any state SHALL immediately force the REQ-032 values; the block SHALL restart per REQ-016 after arst is released.

Verification
REQ-034 Cold boot: defaults, cluster_en=4'hF, release arst -> cken bits rise at edges 3, 5, 7 and 9; grst_l, gdbginit_l and ~rst_busy rise at edge 25.
REQ-035 Mask: cluster_en=4'b0101 -> only cken[0] (edge 3) and cken[2] (edge 7) rise; grst_l still rises at edge 25.
REQ-036 Debug init: in RUN, 1-cycle dbg_req -> gdbginit_l low for 8 cycles; dbg_ack pulse on the rising edge; grst_l=1 and cken=4'hF throughout; a second dbg_req during DBG is ignored.
REQ-037 Warm reset: wrst_req held 5 cycles in RUN -> next edge cken=0, grst_l=0, rst_busy=1; after wrst_req falls, cken[0] rises 2 edges later and grst_l rises 24 edges later.
REQ-038 Collision and abort: wrst_req and dbg_req together in RUN -> WRST with no DBG entry; wrst_req at DBG cycle 3 -> WRST with no dbg_ack.
REQ-039 Async reset: arst pulsed between gclk edges during HOLD -> outputs take REQ-032 values before the next edge; the sequence restarts from edge 1.
